// File: rtl/noc_axi4_bridge_pkg.sv
// -----------------------------------------------------------------------------
// noc_axi4_bridge_pkg
// Shared types for the NoC-AXI4 bridge response tracker.
//   - NUM_IDS_DEF : default number of outstanding transactions / AXI IDs
//   - resp_e      : AXI RRESP/BRESP encoding
//   - slot_t      : one tracking slot {vld, hdr}
//   - resp_is_err : true for SLVERR/DECERR
// Width macros MSG_HEADER_WIDTH and AXI4_DATA_WIDTH get defaults here when the
// surrounding build does not provide them.
// -----------------------------------------------------------------------------
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 64
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

package noc_axi4_bridge_pkg;

   localparam int NUM_IDS_DEF = 4;
   localparam int HDR_W       = `MSG_HEADER_WIDTH;
   localparam int DATA_W      = `AXI4_DATA_WIDTH;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef struct packed {
      logic             vld;
      logic [HDR_W-1:0] hdr;
   } slot_t;

   function automatic logic resp_is_err(input resp_e resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/noc_axi4_bridge_id_alloc.sv
// -----------------------------------------------------------------------------
// noc_axi4_bridge_id_alloc
// Lowest-free-slot priority encoder plus occupancy popcount.
// Ports:
//   slot_vld_i [NUM_IDS]   occupancy vector (registered view)
//   free_id_o  [ID_WIDTH]  lowest index with slot_vld_i=0; 0 when full
//   free_o                 at least one slot is free
//   count_o    [ID_WIDTH+1] number of occupied slots
// -----------------------------------------------------------------------------
module noc_axi4_bridge_id_alloc
   import noc_axi4_bridge_pkg::*;
#(
   parameter int NUM_IDS  = NUM_IDS_DEF,
   parameter int ID_WIDTH = $clog2(NUM_IDS)
) (
   input  logic [NUM_IDS-1:0]  slot_vld_i,
   output logic [ID_WIDTH-1:0] free_id_o,
   output logic                free_o,
   output logic [ID_WIDTH:0]   count_o
);

   // Scan high to low so the last assignment wins with the lowest free index.
   always_comb begin
      free_id_o = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (!slot_vld_i[i]) free_id_o = ID_WIDTH'(i);
      end
   end

   always_comb begin
      count_o = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         count_o = count_o + {{ID_WIDTH{1'b0}}, slot_vld_i[i]};
      end
   end

   assign free_o = ~&slot_vld_i;

endmodule

// File: rtl/noc_axi4_bridge_resp_track.sv
// -----------------------------------------------------------------------------
// noc_axi4_bridge_resp_track
// Tracks outstanding AXI4 transactions of the NoC-AXI4 bridge: allocates an
// AXI ID per request, stores its NoC header, matches R/B responses back by ID
// and presents {header, data} through a one-entry output register.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   alloc_val/alloc_rdy/alloc_header/alloc_id   ID allocation handshake
//   m_axi_r*  (rvalid/rready/rid/rdata/rresp/rlast)  AXI read response
//   m_axi_b*  (bvalid/bready/bid/bresp)              AXI write response
//   header_out/data_out/out_val/out_rdy              output register
//   outstanding                     number of occupied slots
//   spurious                        sticky: response for a free ID seen
//   err_cnt (NOC_AXI4_BRIDGE_RESP_ERR_EN only)  saturating error counter
// Optional feature macro: NOC_AXI4_BRIDGE_RESP_ERR_EN
//   defined   : SLVERR/DECERR on R forwards all-ones data; R/B errors counted
//   undefined : err_cnt absent, response codes ignored
// -----------------------------------------------------------------------------
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 64
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

module noc_axi4_bridge_resp_track
   import noc_axi4_bridge_pkg::*;
#(
   parameter int NUM_IDS  = NUM_IDS_DEF,
   parameter int ID_WIDTH = $clog2(NUM_IDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_val,
   output logic                         alloc_rdy,
   input  logic [`MSG_HEADER_WIDTH-1:0] alloc_header,
   output logic [ID_WIDTH-1:0]          alloc_id,
   input  logic                         m_axi_rvalid,
   output logic                         m_axi_rready,
   input  logic [ID_WIDTH-1:0]          m_axi_rid,
   input  logic [`AXI4_DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic [1:0]                   m_axi_rresp,
   input  logic                         m_axi_rlast,
   input  logic                         m_axi_bvalid,
   output logic                         m_axi_bready,
   input  logic [ID_WIDTH-1:0]          m_axi_bid,
   input  logic [1:0]                   m_axi_bresp,
   output logic [`MSG_HEADER_WIDTH-1:0] header_out,
   output logic [`AXI4_DATA_WIDTH-1:0]  data_out,
   output logic                         out_val,
   input  logic                         out_rdy,
`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
   output logic [7:0]                   err_cnt,
`endif
   output logic [ID_WIDTH:0]            outstanding,
   output logic                         spurious
);

   slot_t                        slot_q [NUM_IDS];
   logic [NUM_IDS-1:0]           slot_vld_q;
   logic [NUM_IDS-1:0]           slot_vld_d;
   logic                         out_val_q,  out_val_d;
   logic [`MSG_HEADER_WIDTH-1:0] header_q,   header_d;
   logic [`AXI4_DATA_WIDTH-1:0]  data_q,     data_d;
   logic                         spurious_q, spurious_d;

   logic                         take;
   logic                         r_acc, b_acc, rsp_acc, hit, alloc_fire;
   logic [ID_WIDTH-1:0]          rsp_id;
   logic [`AXI4_DATA_WIDTH-1:0]  rsp_data;

   always_comb begin
      for (int i = 0; i < NUM_IDS; i++) slot_vld_q[i] = slot_q[i].vld;
   end

   noc_axi4_bridge_id_alloc #(
      .NUM_IDS  (NUM_IDS),
      .ID_WIDTH (ID_WIDTH)
   ) u_id_alloc (
      .slot_vld_i (slot_vld_q),
      .free_id_o  (alloc_id),
      .free_o     (alloc_rdy),
      .count_o    (outstanding)
   );

   // Output register can take a new entry when empty or draining this cycle.
   assign take         = ~out_val_q | out_rdy;
   assign m_axi_rready = take;
   assign m_axi_bready = take & ~m_axi_rvalid;

   assign r_acc      = m_axi_rvalid & take;
   assign b_acc      = m_axi_bvalid & take & ~m_axi_rvalid;
   assign rsp_acc    = r_acc | b_acc;
   assign rsp_id     = r_acc ? m_axi_rid : m_axi_bid;
   assign hit        = rsp_acc & slot_q[rsp_id].vld;
   assign alloc_fire = alloc_val & alloc_rdy;

`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
   logic       r_err, b_err;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       unused_rlast;

   assign unused_rlast = m_axi_rlast;
   assign r_err = r_acc & resp_is_err(resp_e'(m_axi_rresp));
   assign b_err = b_acc & resp_is_err(resp_e'(m_axi_bresp));

   always_comb begin
      rsp_data = '0;
      if (r_acc) rsp_data = r_err ? '1 : m_axi_rdata;
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((r_err | b_err) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= 8'd0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_resp;

   // Response codes and rlast carry no meaning in this build.
   assign unused_resp = ^{m_axi_rresp, m_axi_bresp, m_axi_rlast};

   assign rsp_data = r_acc ? m_axi_rdata : '0;
`endif

   // Alloc and free never target the same slot: alloc_id always points at a
   // slot that is currently free, while a hit only frees an occupied one.
   always_comb begin
      slot_vld_d = slot_vld_q;
      if (hit)        slot_vld_d[rsp_id]   = 1'b0;
      if (alloc_fire) slot_vld_d[alloc_id] = 1'b1;
   end

   always_comb begin
      out_val_d  = out_val_q;
      header_d   = header_q;
      data_d     = data_q;
      spurious_d = spurious_q;
      if (hit) begin
         out_val_d = 1'b1;
         header_d  = slot_q[rsp_id].hdr;
         data_d    = rsp_data;
      end else if (out_rdy) begin
         out_val_d = 1'b0;
      end
      if (rsp_acc && !hit) spurious_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IDS; i++) begin
         if (rst) slot_q[i].vld <= 1'b0;
         else     slot_q[i].vld <= slot_vld_d[i];
         if (alloc_fire && (alloc_id == ID_WIDTH'(i))) slot_q[i].hdr <= alloc_header;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_val_q  <= 1'b0;
         header_q   <= '0;
         data_q     <= '0;
         spurious_q <= 1'b0;
      end else begin
         out_val_q  <= out_val_d;
         header_q   <= header_d;
         data_q     <= data_d;
         spurious_q <= spurious_d;
      end
   end

   assign out_val    = out_val_q;
   assign header_out = header_q;
   assign data_out   = data_q;
   assign spurious   = spurious_q;

endmodule

// File: tb/tb_noc_axi4_bridge_resp_track.sv
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 64
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

module tb_noc_axi4_bridge_resp_track;

   localparam int HW  = `MSG_HEADER_WIDTH;
   localparam int DW  = `AXI4_DATA_WIDTH;
   localparam int NI  = 4;
   localparam int IW  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_val;
   logic          alloc_rdy;
   logic [HW-1:0] alloc_header;
   logic [IW-1:0] alloc_id;
   logic          m_axi_rvalid, m_axi_rready;
   logic [IW-1:0] m_axi_rid;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_bvalid, m_axi_bready;
   logic [IW-1:0] m_axi_bid;
   logic [1:0]    m_axi_bresp;
   logic [HW-1:0] header_out;
   logic [DW-1:0] data_out;
   logic          out_val, out_rdy;
   logic [IW:0]   outstanding;
   logic          spurious;
`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
   logic [7:0]    err_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [HW+DW-1:0] exp_q[$];
   logic [HW-1:0]    hdr_tab [8];

   always #5 clk = ~clk;

   noc_axi4_bridge_resp_track #(.NUM_IDS(NI), .ID_WIDTH(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_val    (alloc_val),
      .alloc_rdy    (alloc_rdy),
      .alloc_header (alloc_header),
      .alloc_id     (alloc_id),
      .m_axi_rvalid (m_axi_rvalid),
      .m_axi_rready (m_axi_rready),
      .m_axi_rid    (m_axi_rid),
      .m_axi_rdata  (m_axi_rdata),
      .m_axi_rresp  (m_axi_rresp),
      .m_axi_rlast  (m_axi_rlast),
      .m_axi_bvalid (m_axi_bvalid),
      .m_axi_bready (m_axi_bready),
      .m_axi_bid    (m_axi_bid),
      .m_axi_bresp  (m_axi_bresp),
      .header_out   (header_out),
      .data_out     (data_out),
      .out_val      (out_val),
      .out_rdy      (out_rdy),
`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
      .err_cnt      (err_cnt),
`endif
      .outstanding  (outstanding),
      .spurious     (spurious)
   );

   // Scoreboard: every output-register handshake pops the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_val && out_rdy) begin
         logic [HW+DW-1:0] e;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL out_unexpected: got hdr=%h data=%h, required no output", header_out, data_out);
         end else begin
            e = exp_q.pop_front();
            if ({header_out, data_out} !== e)
               $display("FAIL out_data: got hdr=%h data=%h, required hdr=%h data=%h",
                        header_out, data_out, e[HW+DW-1:DW], e[DW-1:0]);
            else pass_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_val = 0; alloc_header = '0;
      m_axi_rvalid = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1;
      m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = 2'b00;
   endtask

   task automatic do_alloc(input int k);
      alloc_val = 1; alloc_header = hdr_tab[k];
      step();
      alloc_val = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      out_rdy = 1;
      rst = 1;
      step(); step();
      rst = 0;
      @(negedge clk);
      total_cnt++; if (alloc_rdy !== 1'b1) $display("FAIL rst_alloc_rdy: got %b required 1", alloc_rdy); else pass_cnt++;
      total_cnt++; if (alloc_id !== 2'd0) $display("FAIL rst_alloc_id: got %0d required 0", alloc_id); else pass_cnt++;
      total_cnt++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding: got %0d required 0", outstanding); else pass_cnt++;
      total_cnt++; if ({out_val, spurious} !== 2'b00) $display("FAIL rst_flags: got out_val=%b spurious=%b required 0 0", out_val, spurious); else pass_cnt++;
      total_cnt++; if ({header_out, data_out} !== '0) $display("FAIL rst_out_regs: got hdr=%h data=%h required 0", header_out, data_out); else pass_cnt++;
      total_cnt++; if ({m_axi_rready, m_axi_bready} !== 2'b11) $display("FAIL rst_ready: got r=%b b=%b required 1 1", m_axi_rready, m_axi_bready); else pass_cnt++;
      step();
   endtask

   task automatic test_alloc_fill();
      for (int k = 0; k < 4; k++) begin
         alloc_val = 1; alloc_header = hdr_tab[k];
         @(negedge clk);
         total_cnt++; if (alloc_id !== IW'(k) || alloc_rdy !== 1'b1)
            $display("FAIL fill_id_%0d: got id=%0d rdy=%b required id=%0d rdy=1", k, alloc_id, alloc_rdy, k);
         else pass_cnt++;
         step();
      end
      // Allocation attempt while full must be ignored.
      alloc_header = hdr_tab[7];
      @(negedge clk);
      total_cnt++; if (alloc_rdy !== 1'b0) $display("FAIL full_rdy: got %b required 0", alloc_rdy); else pass_cnt++;
      step();
      alloc_val = 0;
      @(negedge clk);
      total_cnt++; if (outstanding !== 3'd4) $display("FAIL full_outstanding: got %0d required 4", outstanding); else pass_cnt++;
      step();
   endtask

   task automatic test_read_full();
      logic [DW-1:0] d;
      d = {(DW/8){8'hA5}};
      m_axi_rvalid = 1; m_axi_rid = 2; m_axi_rdata = d;
      exp_q.push_back({hdr_tab[2], d});
      @(negedge clk);
      total_cnt++; if (m_axi_rready !== 1'b1) $display("FAIL rd_rready: got %b required 1", m_axi_rready); else pass_cnt++;
      step();
      m_axi_rvalid = 0;
      @(negedge clk);
      total_cnt++; if (alloc_id !== 2'd2 || alloc_rdy !== 1'b1)
         $display("FAIL rd_free_id: got id=%0d rdy=%b required id=2 rdy=1", alloc_id, alloc_rdy);
      else pass_cnt++;
      total_cnt++; if (outstanding !== 3'd3) $display("FAIL rd_outstanding: got %0d required 3", outstanding); else pass_cnt++;
      step();
   endtask

   task automatic test_r_b_priority();
      logic [DW-1:0] d;
      d = DW'(64'h1111_2222_3333_4444);
      m_axi_rvalid = 1; m_axi_rid = 1; m_axi_rdata = d;
      m_axi_bvalid = 1; m_axi_bid = 3;
      exp_q.push_back({hdr_tab[1], d});
      @(negedge clk);
      total_cnt++; if ({m_axi_rready, m_axi_bready} !== 2'b10)
         $display("FAIL prio_ready: got r=%b b=%b required 1 0", m_axi_rready, m_axi_bready);
      else pass_cnt++;
      step();
      m_axi_rvalid = 0;
      exp_q.push_back({hdr_tab[3], {DW{1'b0}}});
      @(negedge clk);
      total_cnt++; if (m_axi_bready !== 1'b1) $display("FAIL prio_bready: got %b required 1", m_axi_bready); else pass_cnt++;
      step();
      m_axi_bvalid = 0;
      step();
      @(negedge clk);
      total_cnt++; if (outstanding !== 3'd1 || alloc_id !== 2'd1)
         $display("FAIL prio_state: got outst=%0d id=%0d required outst=1 id=1", outstanding, alloc_id);
      else pass_cnt++;
      step();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d0, d1;
      d0 = DW'(64'hD0D0_0000_0000_00D0);
      d1 = DW'(64'hD1D1_0000_0000_00D1);
      do_alloc(4);  // id 1
      do_alloc(5);  // id 2
      out_rdy = 0;
      m_axi_rvalid = 1; m_axi_rid = 0; m_axi_rdata = d0;
      exp_q.push_back({hdr_tab[0], d0});
      step();
      m_axi_rid = 1; m_axi_rdata = d1;
      m_axi_bvalid = 1; m_axi_bid = 2;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total_cnt++; if ({m_axi_rready, m_axi_bready} !== 2'b00 || out_val !== 1'b1 ||
                          header_out !== hdr_tab[0] || data_out !== d0)
            $display("FAIL hold_%0d: got r=%b b=%b v=%b hdr=%h data=%h required 0 0 1 %h %h",
                     c, m_axi_rready, m_axi_bready, out_val, header_out, data_out, hdr_tab[0], d0);
         else pass_cnt++;
         step();
      end
      out_rdy = 1;
      exp_q.push_back({hdr_tab[4], d1});
      @(negedge clk);
      total_cnt++; if (m_axi_rready !== 1'b1) $display("FAIL release_rready: got %b required 1", m_axi_rready); else pass_cnt++;
      step();
      m_axi_rvalid = 0;
      exp_q.push_back({hdr_tab[5], {DW{1'b0}}});
      step();
      m_axi_bvalid = 0;
      step();
      @(negedge clk);
      total_cnt++; if (outstanding !== 3'd0) $display("FAIL bp_outstanding: got %0d required 0", outstanding); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) do_alloc(k);
      for (int k = 0; k < 4; k++) begin
         m_axi_rvalid = 1; m_axi_rid = IW'(k); m_axi_rdata = DW'(32'hB000 + k);
         exp_q.push_back({hdr_tab[k], DW'(32'hB000 + k)});
         step();
      end
      m_axi_rvalid = 0;
      step();
      // Simultaneous alloc and free: freed id must not be granted the same cycle.
      for (int k = 0; k < 3; k++) do_alloc(k);
      alloc_val = 1; alloc_header = hdr_tab[3];
      m_axi_rvalid = 1; m_axi_rid = 1; m_axi_rdata = DW'(32'hCAFE);
      exp_q.push_back({hdr_tab[1], DW'(32'hCAFE)});
      @(negedge clk);
      total_cnt++; if (alloc_id !== 2'd3) $display("FAIL simul_id: got %0d required 3", alloc_id); else pass_cnt++;
      step();
      alloc_val = 0; m_axi_rvalid = 0;
      @(negedge clk);
      total_cnt++; if (outstanding !== 3'd3 || alloc_id !== 2'd1)
         $display("FAIL simul_state: got outst=%0d id=%0d required outst=3 id=1", outstanding, alloc_id);
      else pass_cnt++;
      step();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) continue;
         m_axi_rvalid = 1; m_axi_rid = IW'(k); m_axi_rdata = DW'(32'hE000 + k);
         exp_q.push_back({hdr_tab[k == 3 ? 3 : k], DW'(32'hE000 + k)});
         step();
      end
      m_axi_rvalid = 0;
      step();
   endtask

   task automatic test_spurious();
      m_axi_bvalid = 1; m_axi_bid = 0;
      step();
      m_axi_bvalid = 0;
      @(negedge clk);
      total_cnt++; if (spurious !== 1'b1 || out_val !== 1'b0)
         $display("FAIL spur_set: got spurious=%b out_val=%b required 1 0", spurious, out_val);
      else pass_cnt++;
      step(); step(); step();
      @(negedge clk);
      total_cnt++; if (spurious !== 1'b1) $display("FAIL spur_sticky: got %b required 1", spurious); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid();
      do_alloc(6);  // id 0
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      total_cnt++; if (spurious !== 1'b0 || outstanding !== 3'd0)
         $display("FAIL midrst_clear: got spurious=%b outst=%0d required 0 0", spurious, outstanding);
      else pass_cnt++;
      step();
      m_axi_rvalid = 1; m_axi_rid = 0; m_axi_rdata = DW'(32'h77);
      step();
      m_axi_rvalid = 0;
      @(negedge clk);
      total_cnt++; if (spurious !== 1'b1 || out_val !== 1'b0)
         $display("FAIL midrst_late: got spurious=%b out_val=%b required 1 0", spurious, out_val);
      else pass_cnt++;
      step();
   endtask

`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
   task automatic test_err();
      do_alloc(6);  // id 0
      m_axi_rvalid = 1; m_axi_rid = 0; m_axi_rdata = DW'(32'h1234); m_axi_rresp = 2'b10;
      exp_q.push_back({hdr_tab[6], {DW{1'b1}}});
      step();
      m_axi_rvalid = 0; m_axi_rresp = 2'b00;
      @(negedge clk);
      total_cnt++; if (err_cnt !== 8'd1) $display("FAIL err_cnt_one: got %0d required 1", err_cnt); else pass_cnt++;
      step();
      m_axi_bvalid = 1; m_axi_bid = 1; m_axi_bresp = 2'b11;
      for (int c = 0; c < 299; c++) step();
      m_axi_bvalid = 0; m_axi_bresp = 2'b00;
      @(negedge clk);
      total_cnt++; if (err_cnt !== 8'd255) $display("FAIL err_cnt_sat: got %0d required 255", err_cnt); else pass_cnt++;
      step();
   endtask
`endif

   initial begin
      for (int k = 0; k < 8; k++) hdr_tab[k] = HW'(64'hC0DE_0000_0000_0000) | HW'(k * 16 + 1);
      rst = 1;
      out_rdy = 1;
      idle_inputs();
      test_reset();
      test_alloc_fill();
      test_read_full();
      test_r_b_priority();
      test_backpressure();
      test_back_to_back();
`ifdef NOC_AXI4_BRIDGE_RESP_ERR_EN
      test_err();
`endif
      test_spurious();
      test_reset_mid();
      step(); step();
      total_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
